// File: rtl/axis_lrelu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : axis_lrelu_sequencer
// Brief    : Routes an AXI-Stream into either the engine config port (header +
//            config beats) or a width-reducing serializer for data beats.
// Revision : 1.0 - initial release
// ============================================================================
module axis_lrelu_sequencer #(
    parameter int WORD_WIDTH       = 32,
    parameter int LANES            = 32,
    parameter int MEMBERS          = 2,
    parameter int CONFIG_BEATS_3X3 = 21,
    parameter int CONFIG_BEATS_1X1 = 13,
    parameter int FILL_DELAY       = 3,
    parameter int TUSER_WIDTH      = 8,
    parameter int I_IS_1X1         = 5,
    parameter int I_IS_BYPASS      = 7
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic                                  s_axis_tlast,
    input  logic [MEMBERS*LANES*WORD_WIDTH-1:0]   s_axis_tdata,
    input  logic [TUSER_WIDTH-1:0]                s_axis_tuser,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast,
    output logic [LANES*WORD_WIDTH-1:0]           m_axis_tdata,
    output logic [TUSER_WIDTH-1:0]                m_axis_tuser,
    output logic                                  cfg_valid,
    input  logic                                  cfg_ready,
    output logic [MEMBERS*LANES*WORD_WIDTH-1:0]   cfg_data,
    output logic [7:0]                            cfg_index,
    output logic                                  cfg_is_1x1,
    output logic                                  cfg_clear,
    output logic                                  err_cfg
);

    localparam int c_BEAT_W = LANES * WORD_WIDTH;
    localparam int c_IN_W   = MEMBERS * c_BEAT_W;
    localparam int c_MW     = (MEMBERS > 1) ? $clog2(MEMBERS) : 1;
    localparam logic [c_MW-1:0] c_LAST_MEMBER = c_MW'(MEMBERS - 1);
    localparam logic [15:0]     c_LOAD_3X3    = 16'(CONFIG_BEATS_3X3 - 2);
    localparam logic [15:0]     c_LOAD_1X1    = 16'(CONFIG_BEATS_1X1 - 2);
    localparam logic [7:0]      c_FILL_LOAD   = 8'(FILL_DELAY - 1);

    typedef enum logic [2:0] {
        S_PASS  = 3'd0,
        S_DRAIN = 3'd1,
        S_CLEAR = 3'd2,
        S_HDR   = 3'd3,
        S_CFG   = 3'd4,
        S_FILL  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_IN_W-1:0]   r_buf;
    logic [TUSER_WIDTH-1:0] r_user;
    logic                r_last;
    logic                r_valid;
    logic [c_MW-1:0]     r_member;
    logic [15:0]         r_count;
    logic [7:0]          r_index;
    logic [7:0]          r_fill;
    logic                r_is_1x1;
    logic                r_err;

    logic w_last_member;
    logic w_ser_ready;
    logic w_m_hs;
    logic w_s_hs;
    logic w_s_ready;
    logic w_cfg_valid;
    logic w_cfg_clear;

    assign w_last_member = (r_member == c_LAST_MEMBER);
    assign w_m_hs        = r_valid & m_axis_tready;
    // Last member leaving this cycle frees the slot for a back-to-back load.
    assign w_ser_ready   = ~r_valid | (w_last_member & m_axis_tready);
    assign w_s_hs        = s_axis_tvalid & s_axis_tready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        w_cfg_valid = 1'b0;
        w_cfg_clear = 1'b0;
        case (r_state)
            S_PASS: begin
                w_s_ready = w_ser_ready;
                if (s_axis_tvalid && w_ser_ready && s_axis_tlast) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_m_hs && r_last && w_last_member) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_cfg_clear = 1'b1;
                w_state_nxt = S_HDR;
            end
            S_HDR: begin
                w_s_ready   = cfg_ready;
                w_cfg_valid = s_axis_tvalid & ~s_axis_tuser[I_IS_BYPASS];
                if (s_axis_tvalid && cfg_ready) begin
                    w_state_nxt = s_axis_tuser[I_IS_BYPASS] ? S_PASS : S_CFG;
                end
            end
            S_CFG: begin
                w_s_ready   = cfg_ready;
                w_cfg_valid = s_axis_tvalid;
                if (s_axis_tvalid && cfg_ready) begin
                    if (r_count == 16'd0) begin
                        w_state_nxt = r_is_1x1 ? S_FILL : S_PASS;
                    end else if (s_axis_tlast) begin
                        w_state_nxt = S_PASS;
                    end
                end
            end
            S_FILL: begin
                if (r_fill == 8'd0) begin
                    w_state_nxt = S_PASS;
                end
            end
            default: w_state_nxt = S_HDR;
        endcase
    end

    // Handshake-visible outputs are forced low for the whole reset interval.
    assign s_axis_tready = w_s_ready & ~areset;
    assign cfg_valid     = w_cfg_valid & ~areset;
    assign cfg_clear     = w_cfg_clear & ~areset;
    assign cfg_data      = s_axis_tdata;
    assign cfg_index     = r_index;
    assign cfg_is_1x1    = r_is_1x1;
    assign err_cfg       = r_err;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_count  <= 16'd0;
            r_index  <= 8'd0;
            r_fill   <= 8'd0;
            r_is_1x1 <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_HDR: begin
                    if (w_s_hs && !s_axis_tuser[I_IS_BYPASS]) begin
                        r_is_1x1 <= s_axis_tuser[I_IS_1X1];
                        r_count  <= s_axis_tuser[I_IS_1X1] ? c_LOAD_1X1 : c_LOAD_3X3;
                        r_index  <= 8'd1;
                    end
                end
                S_CFG: begin
                    if (w_s_hs) begin
                        if (r_count == 16'd0) begin
                            r_index <= 8'd0;
                            r_fill  <= c_FILL_LOAD;
                        end else if (s_axis_tlast) begin
                            r_err   <= 1'b1;
                            r_index <= 8'd0;
                        end else begin
                            r_count <= r_count - 16'd1;
                            r_index <= r_index + 8'd1;
                        end
                    end
                end
                S_FILL: begin
                    if (r_fill != 8'd0) begin
                        r_fill <= r_fill - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Serializer: member 0 sits in the LSBs; later members shift down into place.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_buf    <= '0;
            r_user   <= '0;
            r_last   <= 1'b0;
            r_valid  <= 1'b0;
            r_member <= '0;
        end else if (r_state == S_PASS && w_s_hs) begin
            r_buf    <= s_axis_tdata;
            r_user   <= s_axis_tuser;
            r_last   <= s_axis_tlast;
            r_valid  <= 1'b1;
            r_member <= '0;
        end else if (w_m_hs) begin
            if (w_last_member) begin
                r_valid <= 1'b0;
            end else begin
                r_member <= r_member + 1'b1;
                r_buf    <= r_buf >> c_BEAT_W;
            end
        end
    end

    assign m_axis_tvalid = r_valid;
    assign m_axis_tdata  = r_buf[c_BEAT_W-1:0];
    assign m_axis_tuser  = r_user;
    assign m_axis_tlast  = r_last & w_last_member;

endmodule
`default_nettype wire

// File: tb/tb_axis_lrelu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_lrelu_sequencer
// Brief    : Directed self-checking bench for axis_lrelu_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_lrelu_sequencer;

    localparam int c_BW = 32;
    localparam int c_IW = 64;

    logic              aclk = 1'b0;
    logic              areset;
    logic              s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [c_IW-1:0]   s_axis_tdata;
    logic [7:0]        s_axis_tuser;
    logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [c_BW-1:0]   m_axis_tdata;
    logic [7:0]        m_axis_tuser;
    logic              cfg_valid, cfg_ready, cfg_is_1x1, cfg_clear, err_cfg;
    logic [c_IW-1:0]   cfg_data;
    logic [7:0]        cfg_index;

    logic m_rdy = 1'b1;
    logic bp_en = 1'b0;
    logic bp_tog = 1'b0;
    assign m_axis_tready = bp_en ? bp_tog : m_rdy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cfg_valid_cyc = 0;
    int clear_cnt = 0;
    int t_clear = 0;
    int t_last_m = 0;
    int hold_viol = 0;
    logic        hold_pend = 1'b0;
    logic [40:0] hold_val;
    logic [40:0] m_q[$];
    logic [7:0]  cfg_idx_q[$];
    logic [63:0] cfg_dat_q[$];

    axis_lrelu_sequencer #(
        .WORD_WIDTH(16), .LANES(2), .MEMBERS(2)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .cfg_index(cfg_index), .cfg_is_1x1(cfg_is_1x1), .cfg_clear(cfg_clear),
        .err_cfg(err_cfg)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) bp_tog = bp_en ? ~bp_tog : 1'b0;

    always @(posedge aclk) begin
        cyc++;
        if (!areset) begin
            if (cfg_valid) cfg_valid_cyc++;
            if (cfg_valid && cfg_ready) begin
                cfg_idx_q.push_back(cfg_index);
                cfg_dat_q.push_back(cfg_data);
            end
            if (cfg_clear) begin
                clear_cnt++;
                t_clear = cyc;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                m_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
                if (m_axis_tlast) t_last_m = cyc;
            end
            if (hold_pend && (!m_axis_tvalid ||
                {m_axis_tlast, m_axis_tuser, m_axis_tdata} != hold_val)) hold_viol++;
            hold_pend = m_axis_tvalid && !m_axis_tready;
            hold_val  = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] u, input logic l);
        int n = 0;
        @(negedge aclk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        #1;
        while (!s_axis_tready && n < 200) begin
            @(negedge aclk);
            #1;
            n++;
        end
        if (n >= 200) check("accept_timeout", 64'(n), 64'd0);
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_m(input int cnt);
        int k = 0;
        while (m_q.size() < cnt && k < 200) begin
            @(negedge aclk);
            k++;
        end
        check("out_beat_count", 64'(m_q.size()), 64'(cnt));
    endtask

    initial begin
        int errs;
        int n;
        int lasts;
        areset        = 1'b1;
        cfg_ready     = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        repeat (3) @(negedge aclk);
        #1;
        check("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
        check("rst_cfg_valid", 64'(cfg_valid), 64'd0);
        check("rst_s_ready", 64'(s_axis_tready), 64'd0);
        check("rst_cfg_clear", 64'(cfg_clear), 64'd0);
        check("rst_err", 64'(err_cfg), 64'd0);
        check("rst_index", 64'(cfg_index), 64'd0);
        check("rst_is_1x1", 64'(cfg_is_1x1), 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        s_axis_tvalid = 1'b0;

        // 3x3 configuration then one data beat
        drive_beat(64'hF00D, 8'h00, 1'b0);
        for (int i = 1; i <= 20; i++) drive_beat(64'hC0DE_0000_0000_0000 | 64'(i), 8'h00, i == 20);
        check("c3_cfg_count", 64'(cfg_idx_q.size()), 64'd21);
        errs = 0;
        for (int i = 0; i < cfg_idx_q.size(); i++) if (cfg_idx_q[i] != 8'(i)) errs++;
        check("c3_index_seq", 64'(errs), 64'd0);
        check("c3_hdr_data", cfg_dat_q[0], 64'hF00D);
        check("c3_cfg_data5", cfg_dat_q[5], 64'hC0DE_0000_0000_0005);
        check("c3_is_1x1", 64'(cfg_is_1x1), 64'd0);
        check("c3_index_done", 64'(cfg_index), 64'd0);
        m_q.delete();
        clear_cnt = 0;
        drive_beat(64'hBBBBBBBB_AAAAAAAA, 8'h5A, 1'b1);
        wait_m(2);
        check("c3_out0", 64'(m_q[0]), {23'd0, 1'b0, 8'h5A, 32'hAAAAAAAA});
        check("c3_out1", 64'(m_q[1]), {23'd0, 1'b1, 8'h5A, 32'hBBBBBBBB});
        repeat (3) @(negedge aclk);
        check("c3_clear_cnt", 64'(clear_cnt), 64'd1);

        // 1x1 configuration, fill gap, then data
        cfg_idx_q.delete();
        drive_beat(64'h1111, 8'h20, 1'b0);
        for (int i = 1; i <= 12; i++) drive_beat(64'(i), 8'h00, i == 12);
        check("c1_cfg_count", 64'(cfg_idx_q.size()), 64'd13);
        check("c1_last_index", 64'(cfg_idx_q[12]), 64'd12);
        check("c1_is_1x1", 64'(cfg_is_1x1), 64'd1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'hDDDDDDDD_CCCCCCCC;
        s_axis_tuser  = 8'h01;
        s_axis_tlast  = 1'b1;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge aclk);
            #1;
            if (s_axis_tready) break;
            n++;
        end
        check("c1_fill_cycles", 64'(n), 64'd3);
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        m_q.delete();
        wait_m(2);
        check("c1_out1", 64'(m_q[1]), {23'd0, 1'b1, 8'h01, 32'hDDDDDDDD});

        // Bypass header keeps previous config
        repeat (3) @(negedge aclk);
        cfg_valid_cyc = 0;
        drive_beat(64'h0, 8'h80, 1'b0);
        check("bp_hdr_cfg_valid", 64'(cfg_valid_cyc), 64'd0);
        check("bp_hdr_index", 64'(cfg_index), 64'd0);
        check("bp_hdr_is_1x1", 64'(cfg_is_1x1), 64'd1);
        m_q.delete();
        drive_beat(64'h22222222_11111111, 8'h3C, 1'b1);
        wait_m(2);
        check("bp_out0", 64'(m_q[0]), {23'd0, 1'b0, 8'h3C, 32'h11111111});
        check("bp_out1", 64'(m_q[1]), {23'd0, 1'b1, 8'h3C, 32'h22222222});

        // Backpressure over a 4-beat burst
        repeat (3) @(negedge aclk);
        drive_beat(64'h0, 8'h80, 1'b0);
        m_q.delete();
        clear_cnt = 0;
        bp_en = 1'b1;
        for (int b = 0; b < 4; b++)
            drive_beat({32'h1000_0000 + 32'(2*b+1), 32'h1000_0000 + 32'(2*b)}, 8'h00, b == 3);
        wait_m(8);
        bp_en = 1'b0;
        errs  = 0;
        lasts = 0;
        for (int j = 0; j < m_q.size(); j++) begin
            if (m_q[j][31:0] != 32'h1000_0000 + 32'(j)) errs++;
            if (m_q[j][40]) lasts++;
        end
        check("bkp_data", 64'(errs), 64'd0);
        check("bkp_last_cnt", 64'(lasts), 64'd1);
        check("bkp_last_pos", 64'(m_q[7][40]), 64'd1);
        repeat (3) @(negedge aclk);
        check("bkp_clear_cnt", 64'(clear_cnt), 64'd1);
        check("bkp_clear_after_last", 64'(t_clear), 64'(t_last_m + 1));
        check("bkp_hold", 64'(hold_viol), 64'd0);

        // Short 3x3 config, stall, then mid-burst reset
        drive_beat(64'h0, 8'h00, 1'b0);
        check("sc_index_hdr", 64'(cfg_index), 64'd1);
        @(negedge aclk);
        cfg_ready     = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        check("sc_stall_index", 64'(cfg_index), 64'd1);
        check("sc_stall_ready", 64'(s_axis_tready), 64'd0);
        cfg_ready     = 1'b1;
        s_axis_tvalid = 1'b0;
        for (int i = 1; i <= 5; i++) drive_beat(64'(i), 8'h00, i == 5);
        check("sc_err", 64'(err_cfg), 64'd1);
        check("sc_index", 64'(cfg_index), 64'd0);
        m_rdy = 1'b0;
        m_q.delete();
        drive_beat(64'h44444444_33333333, 8'h00, 1'b0);
        @(negedge aclk);
        m_rdy = 1'b1;
        @(negedge aclk);
        m_rdy = 1'b0;
        #1;
        check("sc_member1_pending", 64'(m_axis_tvalid), 64'd1);
        check("sc_member1_data", 64'(m_axis_tdata), 64'h44444444);
        check("sc_member0_out", (m_q.size() == 1) ? 64'(m_q[0][31:0]) : 64'hDEAD, 64'h33333333);
        check("sc_err_sticky", 64'(err_cfg), 64'd1);
        @(negedge aclk);
        areset = 1'b1;
        #1;
        check("ar_m_valid", 64'(m_axis_tvalid), 64'd0);
        check("ar_err", 64'(err_cfg), 64'd0);
        check("ar_s_ready", 64'(s_axis_tready), 64'd0);
        repeat (2) @(negedge aclk);
        areset        = 1'b0;
        cfg_ready     = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = 8'h00;
        #1;
        check("ar_hdr_ready_lo", 64'(s_axis_tready), 64'd0);
        cfg_ready = 1'b1;
        #1;
        check("ar_hdr_ready_hi", 64'(s_axis_tready), 64'd1);
        check("ar_hdr_cfg_valid", 64'(cfg_valid), 64'd1);
        s_axis_tvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_lrelu_sequencer.md
AXIS_LRELU_SEQUENCER -- requirements
Module: axis_lrelu_sequencer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, meaning bits per lane word.
REQ-002 SHALL have parameter LANES, default 32, meaning lanes per output beat (COPIES*GROUPS*UNITS).
REQ-003 SHALL have parameter MEMBERS, default 2, meaning output beats per input data beat; legal values are 1 to 16.
REQ-004 SHALL have parameter CONFIG_BEATS_3X3, default 21, meaning total config beats (header included) in 3x3 mode.
REQ-005 SHALL have parameter CONFIG_BEATS_1X1, default 13, meaning total config beats (header included) in 1x1 mode; both CONFIG_BEATS values SHALL be at least 2.
REQ-006 SHALL have parameter FILL_DELAY, default 3, meaning idle cycles after 1x1 config; legal values are 1 to 255.
REQ-007 SHALL have parameter TUSER_WIDTH, default 8, with I_IS_1X1 default 5 and I_IS_BYPASS default 7 giving header tuser bit positions.
REQ-008 SHALL have port aclk, input, 1 bit: the single clock.
REQ-009 SHALL have port areset, input, 1 bit: asynchronous active-high reset. This is already decided.
REQ-010 SHALL have s_axis_tvalid/tready/tlast (1 bit each), s_axis_tdata (MEMBERS*LANES*WORD_WIDTH bits) and s_axis_tuser (TUSER_WIDTH bits) as the slave port.
REQ-011 SHALL have m_axis_tvalid/tready/tlast (1 bit each), m_axis_tdata (LANES*WORD_WIDTH bits) and m_axis_tuser (TUSER_WIDTH bits) as the serialized data master.
REQ-012 SHALL have cfg_valid (out), cfg_ready (in), cfg_data (out, full s_axis_tdata width), cfg_index (out, 8 bits), cfg_is_1x1 (out) and cfg_clear (out, 1-cycle pulse) as the engine config port.
REQ-013 SHALL have err_cfg, output, 1 bit: sticky config-framing error flag.

Function
REQ-014 SHALL implement states PASS, DRAIN, CLEAR, HDR, CFG and FILL.
REQ-015 In PASS, an accepted input beat SHALL be loaded into the serializer and emitted as MEMBERS master beats, member 0 first, taken from the LSBs.
REQ-016 In PASS, s_axis_tready = serializer empty OR (last member pending AND m_axis_tready), giving zero-bubble throughput.
REQ-017 m_axis_tuser SHALL equal the tuser of the source beat; m_axis_tlast SHALL be 1 only on member MEMBERS-1 of a beat accepted with tlast.
REQ-018 PASS -> DRAIN on a tlast input handshake; in DRAIN, s_axis_tready SHALL be 0.
REQ-019 DRAIN -> CLEAR on the m_axis handshake carrying tlast.
REQ-020 CLEAR SHALL hold s_axis_tready=0, assert cfg_clear for exactly one cycle, then go to HDR.
REQ-021 In HDR and CFG: cfg_valid=s_axis_tvalid, s_axis_tready=cfg_ready, cfg_data=s_axis_tdata; master valid SHALL be 0.
REQ-022 cfg_index SHALL be 0 for the header and increment per config handshake.
REQ-023 On the HDR handshake with tuser[I_IS_BYPASS]=1, the header SHALL be consumed without cfg_valid, the previous config SHALL be kept, and the state SHALL go to PASS.
REQ-024 On the HDR handshake otherwise: latch cfg_is_1x1=tuser[I_IS_1X1], load count = (1x1 ? CONFIG_BEATS_1X1 : CONFIG_BEATS_3X3)-2, go to CFG.
REQ-025 In CFG, count SHALL decrement per handshake; the handshake at count==0 goes to FILL if 1x1, else PASS.
REQ-026 A config beat with tlast=1 before count==0 SHALL set err_cfg, be forwarded as config, and return the state to PASS.
REQ-027 FILL SHALL hold s_axis_tready=0 and cfg_valid=0 for exactly FILL_DELAY cycles, then go to PASS.
REQ-028 cfg_ready=0 SHALL stall HDR and CFG with no state, count or index change.
REQ-029 m_axis_tready=0 SHALL hold m_axis_tdata, m_axis_tuser and m_axis_tlast stable while m_axis_tvalid=1.
REQ-030 With MEMBERS=1, PASS SHALL act as a one-deep register slice.

Reset
REQ-031 While areset=1, asynchronously: state=HDR, serializer empty, count=0, cfg_index=0, cfg_is_1x1=0.
REQ-032 While areset=1: m_axis_tvalid=0, cfg_valid=0, cfg_clear=0, err_cfg=0 and s_axis_tready=0.
REQ-033 Reset asserted mid-burst SHALL discard partial beats; after release, the first accepted beat is a header.
REQ-034 err_cfg SHALL be cleared only by reset.

Verification
REQ-035 3x3 flow: header tuser=0x00 plus 20 config beats -> cfg_index runs 0..20, then PASS; data beat 0xBBBB..AAAA with tlast (MEMBERS=2) -> out AAAA.. then BBBB.. with tlast only on the second beat.
REQ-036 1x1 flow: header tuser[5]=1 plus 12 config beats -> s_axis_tready=0 for exactly 3 cycles, then data is accepted.
REQ-037 Bypass: header tuser[7]=1 -> no cfg_valid, cfg_index stays 0, the next beat is treated as data.
REQ-038 Backpressure: m_axis_tready toggling 1010 during a 4-beat burst -> no loss or duplication; DRAIN exits only after the last output beat; cfg_clear is high for exactly 1 cycle.
REQ-039 Short config: tlast on config beat 5 in 3x3 mode -> err_cfg=1 and state=PASS; err_cfg stays 1 until areset.
REQ-040 areset pulsed while 1 of 2 members is emitted -> m_axis_tvalid=0 immediately; after release, s_axis_tready follows cfg_ready (HDR).
